// File: rtl/nonce_scheduler.sv
// Nonce search sequencer: feeds one 640-bit header message per nonce to the SHA-256
// hasher over valid/ready and stops on hit, range exhaustion, abort or watchdog expiry.
module nonce_scheduler #(
    parameter int HEADER_BITS    = 608,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [0:HEADER_BITS-1] header_prefix,
    input  logic [0:31]            nonce_start,
    input  logic [0:31]            nonce_end,
    input  logic [0:255]           target,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [0:9]             input_length,
    output logic [0:1023]          binary_input,
    input  logic                   digest_valid,
    input  logic [0:255]           digest,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [0:31]            found_nonce,
    output logic                   timeout_err,
    output logic                   aborted,
    output logic [0:31]            attempts
);

    localparam int MSG_BITS = HEADER_BITS + 32;
    localparam int WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t                 r_state;
    logic [0:HEADER_BITS-1] r_prefix;
    logic [0:31]            r_nonce;
    logic [0:31]            r_nonce_end;
    logic [0:255]           r_target;
    logic [0:255]           r_digest;
    logic [WD_W-1:0]        r_wdog;
    logic                   r_abort_pending;
    logic                   r_msg_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_found;
    logic [0:31]            r_found_nonce;
    logic                   r_timeout_err;
    logic                   r_aborted;
    logic [0:31]            r_attempts;

    logic                   w_hit;
    logic                   w_abort_req;
    logic                   w_run_state;
    logic [0:MSG_BITS-1]    w_msg;

    // Nonce travels little-endian inside the header, as the block header format requires.
    assign w_msg        = {r_prefix, r_nonce[24:31], r_nonce[16:23], r_nonce[8:15], r_nonce[0:7]};
    assign binary_input = {w_msg, {(1024 - MSG_BITS){1'b0}}};
    assign input_length = 10'(MSG_BITS);

    assign w_hit       = (r_digest < r_target);
    assign w_abort_req = r_abort_pending | abort;
    assign w_run_state = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_CHECK);

    assign msg_valid   = r_msg_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign timeout_err = r_timeout_err;
    assign aborted     = r_aborted;
    assign attempts    = r_attempts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_prefix        <= '0;
            r_nonce         <= '0;
            r_nonce_end     <= '0;
            r_target        <= '0;
            r_digest        <= '0;
            r_wdog          <= '0;
            r_abort_pending <= 1'b0;
            r_msg_valid     <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_found         <= 1'b0;
            r_found_nonce   <= '0;
            r_timeout_err   <= 1'b0;
            r_aborted       <= 1'b0;
            r_attempts      <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && w_run_state) begin
                r_abort_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_prefix        <= header_prefix;
                        r_nonce         <= nonce_start;
                        r_nonce_end     <= nonce_end;
                        r_target        <= target;
                        r_found         <= 1'b0;
                        r_found_nonce   <= '0;
                        r_timeout_err   <= 1'b0;
                        r_aborted       <= 1'b0;
                        r_attempts      <= '0;
                        r_abort_pending <= 1'b0;
                        r_msg_valid     <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (msg_ready) begin
                        r_msg_valid <= 1'b0;
                        r_wdog      <= '0;
                        r_state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (digest_valid) begin
                        r_digest <= digest;
                        if (r_attempts != 32'hFFFF_FFFF) begin
                            r_attempts <= r_attempts + 32'd1;
                        end
                        r_state <= ST_CHECK;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_wdog == WD_LAST)) begin
                        r_timeout_err <= 1'b1;
                        r_found       <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end

                ST_CHECK: begin
                    // Hit outranks abort so a winning nonce is never discarded.
                    if (w_hit || w_abort_req || (r_nonce == r_nonce_end)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                        if (w_hit) begin
                            r_found       <= 1'b1;
                            r_found_nonce <= r_nonce;
                        end else if (w_abort_req) begin
                            r_aborted <= 1'b1;
                        end
                    end else begin
                        r_nonce     <= r_nonce + 32'd1;
                        r_msg_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Randomised scoreboard bench for nonce_scheduler: a behavioural hasher responds to
// messages, a search-level model predicts each result, and a monitor checks every done.
module tb_nonce_scheduler;

    localparam int TO = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [607:0]   header_prefix = '0;
    logic [31:0]    nonce_start = '0;
    logic [31:0]    nonce_end = '0;
    logic [255:0]   target = '0;
    logic           msg_valid;
    logic           msg_ready = 1'b0;
    logic [9:0]     input_length;
    logic [0:1023]  binary_input;
    logic           digest_valid = 1'b0;
    logic [255:0]   digest = '0;
    logic           busy, done, found, timeout_err, aborted;
    logic [31:0]    found_nonce, attempts;

    nonce_scheduler #(.HEADER_BITS(608), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .header_prefix(header_prefix), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .input_length(input_length), .binary_input(binary_input),
        .digest_valid(digest_valid), .digest(digest), .busy(busy), .done(done),
        .found(found), .found_nonce(found_nonce), .timeout_err(timeout_err),
        .aborted(aborted), .attempts(attempts)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Hasher behaviour and search configuration
    logic [31:0]  seed = 32'h1234_5678;
    logic [31:0]  force_n = '0;
    bit           force_en = 1'b0;
    bit           no_respond = 1'b0;
    bit           idle_abort_req = 1'b0;
    int           abort_at = 0;
    int           rdy_min = 0, rdy_max = 0, dig_min = 1, dig_max = 1;
    int           hs_count = 0;
    int           last_hs_cyc = 0;
    int           done_cyc = 0;
    logic [607:0] cur_prefix = '0;

    typedef struct {
        bit          f;
        logic [31:0] fn;
        logic [31:0] att;
        bit          ab;
        bit          to;
    } res_t;
    res_t        exp_q[$];
    logic [31:0] exp_nonce_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mix(input logic [31:0] n, input logic [31:0] s);
        logic [255:0] r;
        logic [31:0]  w;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            w = (n ^ s) * 32'h9E37_79B1 + 32'(i + 1) * 32'h85EB_CA77;
            w = w ^ (w >> 15);
            w = w * 32'h2C1B_3C6D;
            w = w ^ (w >> 12);
            r[i*32 +: 32] = w;
        end
        return r;
    endfunction

    function automatic logic [255:0] hd(input logic [31:0] n);
        if (force_en && n == force_n) return '0;
        return mix(n, seed);
    endfunction

    // Behavioural hasher: random backpressure and digest latency, optional abort injection.
    initial begin
        bit          in_msg, hs, waiting;
        int          rdy_cnt, rdy_tgt, dig_cnt, dig_tgt;
        logic [0:1023] held;
        logic [31:0] w, cur_n;
        in_msg = 0; hs = 0; waiting = 0;
        rdy_cnt = 0; rdy_tgt = 0; dig_cnt = 0; dig_tgt = 1;
        held = '0; cur_n = '0;
        forever begin
            @(negedge clk);
            digest_valid = 1'b0;
            abort = 1'b0;
            if (!rst_n) begin
                msg_ready = 1'b0; in_msg = 0; hs = 0; waiting = 0;
                continue;
            end
            if (!busy) waiting = 0;
            if (idle_abort_req) begin
                abort = 1'b1;
                idle_abort_req = 1'b0;
            end
            if (hs) begin
                msg_ready = 1'b0;
                hs = 0;
                waiting = 1;
                dig_cnt = 0;
                if (hs_count == abort_at) abort = 1'b1;
            end
            if (waiting) begin
                dig_cnt++;
                if (!no_respond && dig_cnt >= dig_tgt) begin
                    digest_valid = 1'b1;
                    digest = hd(cur_n);
                    waiting = 0;
                end
            end else if (msg_valid) begin
                if (!in_msg) begin
                    in_msg = 1;
                    held = binary_input;
                    rdy_cnt = 0;
                    rdy_tgt = $urandom_range(rdy_max, rdy_min);
                    chk("bi_prefix", binary_input[0:607] == cur_prefix, 1);
                    chk("bi_pad", binary_input[640:1023] == 384'b0, 1);
                end else begin
                    chk("bi_stable", binary_input == held, 1);
                end
                if (rdy_cnt >= rdy_tgt) begin
                    msg_ready = 1'b1;
                    hs = 1;
                    in_msg = 0;
                    hs_count++;
                    last_hs_cyc = cyc;
                    w = binary_input[608:639];
                    cur_n = {w[7:0], w[15:8], w[23:16], w[31:24]};
                    dig_tgt = $urandom_range(dig_max, dig_min);
                    if (exp_nonce_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL nonce_extra: got %0h expected no handshake", cur_n);
                    end else begin
                        chk("nonce", cur_n, exp_nonce_q.pop_front());
                    end
                end else begin
                    rdy_cnt++;
                end
            end else if (in_msg) begin
                chk("valid_held", msg_valid, 1);
                in_msg = 0;
            end
        end
    end

    // Monitor: every done pulse is matched against the oldest predicted result.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL done_unexpected: got done=1 expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    chk("found", found, e.f);
                    chk("found_nonce", found_nonce, e.fn);
                    chk("attempts", attempts, e.att);
                    chk("aborted", aborted, e.ab);
                    chk("timeout_err", timeout_err, e.to);
                    chk("busy_at_done", busy, 0);
                    chk("nonces_left", exp_nonce_q.size(), 0);
                end
            end
        end
    end

    task automatic launch(input logic [31:0] s, input logic [31:0] en,
                          input logic [255:0] tg, input bit push_res);
        res_t        r;
        logic [31:0] n, swp;
        for (int i = 0; i < 19; i++) header_prefix[i*32 +: 32] = $urandom;
        cur_prefix  = header_prefix;
        nonce_start = s;
        nonce_end   = en;
        target      = tg;
        hs_count    = 0;
        r = '{f: 0, fn: 0, att: 0, ab: 0, to: 0};
        n = s;
        for (int k = 1; k <= 64; k++) begin
            exp_nonce_q.push_back(n);
            if (no_respond) begin
                r.to = 1;
                break;
            end
            if (hd(n) < tg) begin
                r.f = 1; r.fn = n; r.att = 32'(k);
                break;
            end
            if (k == abort_at) begin
                r.ab = 1; r.att = 32'(k);
                break;
            end
            if (n == en) begin
                r.att = 32'(k);
                break;
            end
            n = n + 32'd1;
        end
        if (push_res) exp_q.push_back(r);
        start = 1'b1;
        @(negedge clk);
        swp = {<<8{s}};
        chk("start_valid", msg_valid, 1);
        chk("start_found_clr", found, 0);
        chk("start_attempts_clr", attempts, 0);
        chk("bi_nonce_le", binary_input[608:639], swp);
        header_prefix = ~header_prefix;
        nonce_start   = ~s;
        nonce_end     = ~en;
        target        = ~tg;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset_flush();
        exp_q.delete();
        exp_nonce_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 3000);
        done_cyc = cyc;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL done_wait: got no done in %0d cycles expected done", t);
            #2 rst_n = 1'b0;
            do_reset_flush();
        end else begin
            @(negedge clk);
            chk("done_pulse", done, 0);
        end
    endtask

    initial begin
        logic [255:0] tg;
        logic [31:0]  s;
        int           len, t;

        repeat (3) @(negedge clk);
        chk("rst_msg_valid", msg_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_found_nonce", found_nonce, 0);
        chk("rst_attempts", attempts, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_aborted", aborted, 0);
        chk("input_length", input_length, 640);
        rst_n = 1'b1;
        @(negedge clk);

        // Single hit, with an abort pulse in IDLE that must be ignored
        idle_abort_req = 1;
        repeat (2) @(negedge clk);
        launch(32'd5, 32'd9, {256{1'b1}}, 1);
        wait_done();

        // Exhaustion
        rdy_min = 0; rdy_max = 3; dig_min = 1; dig_max = 4;
        launch(32'h10, 32'h13, '0, 1);
        wait_done();

        // Wrap-around
        launch(32'hFFFF_FFFE, 32'h0000_0001, '0, 1);
        wait_done();

        // Backpressure and long digest latency, hit on nonce 3
        rdy_min = 7; rdy_max = 7; dig_min = 20; dig_max = 20;
        force_en = 1; force_n = 32'd3;
        launch(32'd1, 32'd5, 256'd1, 1);
        wait_done();

        // Abort on the 2nd nonce, first without then with a hit
        rdy_min = 0; rdy_max = 2; dig_min = 1; dig_max = 3;
        force_en = 0; abort_at = 2;
        launch(32'd100, 32'd107, 256'd1, 1);
        wait_done();
        force_en = 1; force_n = 32'd101;
        launch(32'd100, 32'd107, 256'd1, 1);
        wait_done();
        force_en = 0; abort_at = 0;

        // Watchdog
        no_respond = 1;
        launch(32'd7, 32'd20, {256{1'b1}}, 1);
        wait_done();
        chk("timeout_cycles", done_cyc - last_hs_cyc, TO + 1);

        // Reset while waiting for a digest, then a normal search
        launch(32'd40, 32'd50, {256{1'b1}}, 0);
        t = 0;
        while (!(busy && !msg_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reached_wait", busy && !msg_valid, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_msg_valid", msg_valid, 0);
        chk("arst_attempts", attempts, 0);
        chk("arst_flags", {found, timeout_err, aborted, done}, 0);
        do_reset_flush();
        no_respond = 0;
        launch(32'd60, 32'd62, '0, 1);
        wait_done();

        // Reset while a message is offered under backpressure
        rdy_min = 50; rdy_max = 50;
        launch(32'd70, 32'd71, '0, 0);
        repeat (3) @(negedge clk);
        chk("issue_valid", msg_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_issue_valid", msg_valid, 0);
        chk("arst_issue_busy", busy, 0);
        do_reset_flush();

        // Randomised searches
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(8, 1);
            if ($urandom_range(3, 0) == 0) s = 32'hFFFF_FFFF - 32'($urandom_range(6, 0));
            else s = $urandom;
            tg = '0;
            for (int i = 0; i < 7; i++) tg[i*32 +: 32] = $urandom;
            tg[255:224] = 32'($urandom_range(32'h3000_0000, 0));
            abort_at = ($urandom_range(2, 0) == 0) ? $urandom_range(len, 1) : 0;
            force_en = ($urandom_range(3, 0) == 0);
            force_n  = s + 32'($urandom_range(len - 1, 0));
            rdy_min = 0; rdy_max = 3; dig_min = 1; dig_max = 6;
            seed = $urandom;
            launch(s, s + 32'(len - 1), tg, 1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
